// File: rtl/isb_pkg.sv
// Shared constants, types and helpers for the ISB prefetcher.
package isb_pkg;

  localparam int unsigned TU_ENTRIES  = 4;
  localparam int unsigned PS_ENTRIES  = 32;
  localparam int unsigned SP_ENTRIES  = 64;
  localparam int unsigned CHUNK       = 16;
  localparam logic [15:0] CHUNK_INIT  = 16'h0100;

  localparam int unsigned SP_IDX_W    = 6;
  localparam int unsigned SP_TAG_W    = 16 - SP_IDX_W;

  typedef logic [15:0] addr_t;
  typedef logic [15:0] saddr_t;

  typedef struct packed {
    logic  valid;
    addr_t pc;
    addr_t last_addr;
  } tu_entry_t;

  typedef struct packed {
    logic   valid;
    addr_t  addr;
    saddr_t s;
  } ps_entry_t;

  typedef struct packed {
    logic                valid;
    logic [SP_TAG_W-1:0] tag;
    addr_t               data;
  } sp_entry_t;

  typedef enum logic {
    PROBE_IDLE,
    PROBE_RUN
  } probe_state_e;

  function automatic logic [SP_IDX_W-1:0] sp_idx(input saddr_t s);
    return s[SP_IDX_W-1:0];
  endfunction

  function automatic logic [SP_TAG_W-1:0] sp_tag(input saddr_t s);
    return s[15:SP_IDX_W];
  endfunction

endpackage

// File: rtl/isb_prefetcher_if.sv
// Demand-access / prefetch-request bundle between the core side and the ISB prefetcher.
interface isb_prefetcher_if;

  logic           v_in;
  isb_pkg::addr_t pc;
  isb_pkg::addr_t addr;
  logic           pf_valid;
  isb_pkg::addr_t pf_addr;

  modport master (
    output v_in, pc, addr,
    input  pf_valid, pf_addr
  );

  modport slave (
    input  v_in, pc, addr,
    output pf_valid, pf_addr
  );

endinterface

// File: rtl/isb_assoc_table.sv
// Fully associative tag/data table with round-robin allocation; used for the TU and PS maps.
// ENTRIES must be a power of two so the round-robin pointer wraps naturally.
module isb_assoc_table #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned TAG_W   = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned N_LK    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_LK-1:0][TAG_W-1:0]    lk_tag,
  output logic [N_LK-1:0]               lk_hit,
  output logic [N_LK-1:0][DATA_W-1:0]   lk_data,
  input  logic                          wr_en,
  input  logic [TAG_W-1:0]              wr_tag,
  input  logic [DATA_W-1:0]             wr_data
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [TAG_W-1:0]   tag_d  [ENTRIES];
  logic [DATA_W-1:0]  data_q [ENTRIES];
  logic [DATA_W-1:0]  data_d [ENTRIES];
  logic [IDX_W-1:0]   rr_q, rr_d;

  logic               wr_hit;
  logic [IDX_W-1:0]   wr_idx;

  always_comb begin : lookup
    lk_hit  = '0;
    lk_data = '0;
    for (int unsigned p = 0; p < N_LK; p++) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (!lk_hit[p] && valid_q[i] && (tag_q[i] == lk_tag[p])) begin
          lk_hit[p]  = 1'b1;
          lk_data[p] = data_q[i];
        end
      end
    end
  end

  // A write to a resident tag updates in place; only a miss consumes a round-robin slot.
  always_comb begin : update
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    rr_d    = rr_q;
    wr_hit  = 1'b0;
    wr_idx  = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!wr_hit && valid_q[i] && (tag_q[i] == wr_tag)) begin
        wr_hit = 1'b1;
        wr_idx = IDX_W'(i);
      end
    end
    if (wr_en) begin
      if (wr_hit) begin
        data_d[wr_idx] = wr_data;
      end else begin
        valid_d[rr_q] = 1'b1;
        tag_d[rr_q]   = wr_tag;
        data_d[rr_q]  = wr_data;
        rr_d          = rr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
      rr_q    <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: rtl/isb_prefetcher.sv
// Irregular Stream Buffer prefetcher: maps PC-localised address streams to structural space
// and replays structural successors as prefetches. ISB_STATS_EN adds access/prefetch counters.
module isb_prefetcher
  import isb_pkg::*;
#(
  parameter int unsigned DEGREE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  isb_prefetcher_if.slave  bus
`ifdef ISB_STATS_EN
  ,
  output logic [15:0]      stat_acc,
  output logic [15:0]      stat_pf
`endif
);

  logic                tu_hit;
  addr_t               tu_last;
  logic [1:0]          ps_hit;
  logic [1:0][15:0]    ps_data;

  tu_entry_t           tu_wr;
  ps_entry_t           ps_wr;
  saddr_t              s_cur, s_last, s_inc, s_new;
  saddr_t              next_chunk_q, next_chunk_d;
  logic                new_chunk;

  sp_entry_t           sp_q [SP_ENTRIES];
  sp_entry_t           sp_d [SP_ENTRIES];

  probe_state_e        state_q, state_d;
  saddr_t              base_q, base_d;
  logic [2:0]          k_q, k_d;
  logic                pf_valid_q, pf_valid_d;
  addr_t               pf_addr_q, pf_addr_d;
  saddr_t              probe_s;
  sp_entry_t           probe_e;

  isb_assoc_table #(
    .ENTRIES (TU_ENTRIES),
    .TAG_W   (16),
    .DATA_W  (16),
    .N_LK    (1)
  ) u_tu (
    .clk     (clk),
    .rst_n   (rst_n),
    .lk_tag  (bus.pc),
    .lk_hit  (tu_hit),
    .lk_data (tu_last),
    .wr_en   (tu_wr.valid),
    .wr_tag  (tu_wr.pc),
    .wr_data (tu_wr.last_addr)
  );

  // Port 0 looks up the current address, port 1 the PC's previous address.
  isb_assoc_table #(
    .ENTRIES (PS_ENTRIES),
    .TAG_W   (16),
    .DATA_W  (16),
    .N_LK    (2)
  ) u_ps (
    .clk     (clk),
    .rst_n   (rst_n),
    .lk_tag  ({tu_last, bus.addr}),
    .lk_hit  (ps_hit),
    .lk_data (ps_data),
    .wr_en   (ps_wr.valid),
    .wr_tag  (ps_wr.addr),
    .wr_data (ps_wr.s)
  );

  always_comb begin : train
    s_cur     = ps_data[0];
    s_last    = ps_data[1];
    s_inc     = s_last + 16'd1;
    new_chunk = 1'b1;
    s_new     = next_chunk_q;
    // Extend the stream only while staying inside the predecessor's chunk.
    if (tu_hit && ps_hit[1] && (s_inc[3:0] != 4'd0)) begin
      new_chunk = 1'b0;
      s_new     = s_inc;
    end
    tu_wr = '{valid: bus.v_in, pc: bus.pc, last_addr: bus.addr};
    ps_wr = '{valid: bus.v_in && !ps_hit[0], addr: bus.addr, s: s_new};
    next_chunk_d = next_chunk_q;
    if (ps_wr.valid && new_chunk) begin
      next_chunk_d = next_chunk_q + saddr_t'(CHUNK);
    end
  end

  always_comb begin : sp_update
    sp_d = sp_q;
    if (ps_wr.valid) begin
      sp_d[sp_idx(ps_wr.s)] = '{valid: 1'b1, tag: sp_tag(ps_wr.s), data: ps_wr.addr};
    end
  end

  always_comb begin : probe
    state_d    = state_q;
    base_d     = base_q;
    k_d        = k_q;
    pf_valid_d = 1'b0;
    pf_addr_d  = pf_addr_q;
    probe_s    = base_q + saddr_t'(k_q);
    probe_e    = sp_q[sp_idx(probe_s)];
    if (bus.v_in) begin
      if (ps_hit[0]) begin
        state_d = PROBE_RUN;
        base_d  = s_cur;
        k_d     = 3'd1;
      end else begin
        state_d = PROBE_IDLE;
      end
    end else if (state_q == PROBE_RUN) begin
      if (probe_e.valid && (probe_e.tag == sp_tag(probe_s))) begin
        pf_valid_d = 1'b1;
        pf_addr_d  = probe_e.data;
      end
      if (k_q == 3'(DEGREE)) begin
        state_d = PROBE_IDLE;
      end else begin
        k_d = k_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PROBE_IDLE;
      base_q       <= '0;
      k_q          <= '0;
      pf_valid_q   <= 1'b0;
      pf_addr_q    <= '0;
      next_chunk_q <= CHUNK_INIT;
      sp_q         <= '{default: '0};
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      k_q          <= k_d;
      pf_valid_q   <= pf_valid_d;
      pf_addr_q    <= pf_addr_d;
      next_chunk_q <= next_chunk_d;
      sp_q         <= sp_d;
    end
  end

  assign bus.pf_valid = pf_valid_q;
  assign bus.pf_addr  = pf_addr_q;

`ifdef ISB_STATS_EN
  logic [15:0] stat_acc_q, stat_acc_d;
  logic [15:0] stat_pf_q, stat_pf_d;

  always_comb begin : stats
    stat_acc_d = stat_acc_q;
    stat_pf_d  = stat_pf_q;
    if (bus.v_in && (stat_acc_q != '1)) begin
      stat_acc_d = stat_acc_q + 16'd1;
    end
    if (pf_valid_d && (stat_pf_q != '1)) begin
      stat_pf_d = stat_pf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_acc_q <= '0;
      stat_pf_q  <= '0;
    end else begin
      stat_acc_q <= stat_acc_d;
      stat_pf_q  <= stat_pf_d;
    end
  end

  assign stat_acc = stat_acc_q;
  assign stat_pf  = stat_pf_q;
`endif

endmodule

// File: tb/tb_isb_prefetcher.sv
// Scoreboard bench for isb_prefetcher: DEGREE=1 and DEGREE=2 instances driven in lockstep.
module tb_isb_prefetcher;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  isb_prefetcher_if if1 ();
  isb_prefetcher_if if2 ();

`ifdef ISB_STATS_EN
  logic [15:0] sa1, sp1, sa2, sp2;
`endif

  isb_prefetcher #(.DEGREE(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
`ifdef ISB_STATS_EN
    ,
    .stat_acc (sa1),
    .stat_pf  (sp1)
`endif
  );

  isb_prefetcher #(.DEGREE(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.slave)
`ifdef ISB_STATS_EN
    ,
    .stat_acc (sa2),
    .stat_pf  (sp2)
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic [15:0] a;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  // Expected output after each edge is compared 1 time unit after that edge.
  always @(posedge clk) begin : mon1
    exp_t e;
    #1;
    if (q1.size() > 0) begin
      e = q1.pop_front();
      total++;
      if ((if1.pf_valid !== e.v) || (e.v && (if1.pf_addr !== e.a))) begin
        bad++;
        $display("FAIL pf_deg1 t=%0t got v=%b a=%h want v=%b a=%h",
                 $time, if1.pf_valid, if1.pf_addr, e.v, e.a);
      end
    end
  end

  always @(posedge clk) begin : mon2
    exp_t e;
    #1;
    if (q2.size() > 0) begin
      e = q2.pop_front();
      total++;
      if ((if2.pf_valid !== e.v) || (e.v && (if2.pf_addr !== e.a))) begin
        bad++;
        $display("FAIL pf_deg2 t=%0t got v=%b a=%h want v=%b a=%h",
                 $time, if2.pf_valid, if2.pf_addr, e.v, e.a);
      end
    end
  end

  task automatic step(input logic v, input logic [15:0] p, input logic [15:0] a,
                      input logic e1v, input logic [15:0] e1a,
                      input logic e2v, input logic [15:0] e2a);
    if1.v_in = v; if1.pc = p; if1.addr = a;
    if2.v_in = v; if2.pc = p; if2.addr = a;
    q1.push_back('{e1v, e1a});
    q2.push_back('{e2v, e2a});
    @(negedge clk);
  endtask

  task automatic idle(input logic e1v, input logic [15:0] e1a,
                      input logic e2v, input logic [15:0] e2a);
    step(1'b0, 16'h0, 16'h0, e1v, e1a, e2v, e2a);
  endtask

  task automatic test_reset;
    if1.v_in = 1'b0; if1.pc = '0; if1.addr = '0;
    if2.v_in = 1'b0; if2.pc = '0; if2.addr = '0;
    #1 rst_n = 1'b0;
    #2;
    total += 2;
    if (if1.pf_valid !== 1'b0 || if1.pf_addr !== 16'h0) begin
      bad++;
      $display("FAIL reset_deg1 got v=%b a=%h want v=0 a=0000", if1.pf_valid, if1.pf_addr);
    end
    if (if2.pf_valid !== 1'b0 || if2.pf_addr !== 16'h0) begin
      bad++;
      $display("FAIL reset_deg2 got v=%b a=%h want v=0 a=0000", if2.pf_valid, if2.pf_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_cold_stream;
    for (int unsigned i = 0; i < 5; i++)
      step(1'b1, 16'h0000, 16'h0010 + 16'(i), 1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_second_stream;
    step(1'b1, 16'h0001, 16'h0020, 1'b0, 16'h0, 1'b0, 16'h0);
    step(1'b1, 16'h0001, 16'h0021, 1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_replay;
    step(1'b1, 16'h0000, 16'h0010, 1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b1, 16'h0011, 1'b1, 16'h0011);
    idle(1'b0, 16'h0,    1'b1, 16'h0012);
    idle(1'b0, 16'h0,    1'b0, 16'h0);
    step(1'b1, 16'h0000, 16'h0013, 1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b1, 16'h0014, 1'b1, 16'h0014);
    idle(1'b0, 16'h0,    1'b0, 16'h0);
    idle(1'b0, 16'h0,    1'b0, 16'h0);
  endtask

  task automatic test_end_of_stream;
    step(1'b1, 16'h0001, 16'h0021, 1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b0, 16'h0, 1'b0, 16'h0);
    step(1'b1, 16'h0001, 16'h0020, 1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b1, 16'h0021, 1'b1, 16'h0021);
    idle(1'b0, 16'h0,    1'b0, 16'h0);
    idle(1'b0, 16'h0,    1'b0, 16'h0);
  endtask

  task automatic test_chunk_overflow;
    for (int unsigned i = 0; i < 17; i++)
      step(1'b1, 16'h0002, 16'h0040 + 16'(i), 1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b0, 16'h0, 1'b0, 16'h0);
    step(1'b1, 16'h0002, 16'h004F, 1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b1, 16'h0050, 1'b1, 16'h0050);
    idle(1'b0, 16'h0,    1'b0, 16'h0);
    step(1'b1, 16'h0002, 16'h0040, 1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b1, 16'h0041, 1'b1, 16'h0041);
    idle(1'b0, 16'h0,    1'b1, 16'h0042);
    idle(1'b0, 16'h0,    1'b0, 16'h0);
  endtask

  task automatic test_back_to_back;
    step(1'b1, 16'h0000, 16'h0010, 1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b1, 16'h0011, 1'b1, 16'h0011);
    step(1'b1, 16'h0000, 16'h0013, 1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b1, 16'h0014, 1'b1, 16'h0014);
    idle(1'b0, 16'h0,    1'b0, 16'h0);
    idle(1'b0, 16'h0,    1'b0, 16'h0);
  endtask

  task automatic test_reset_mid;
    step(1'b1, 16'h0000, 16'h0010, 1'b0, 16'h0, 1'b0, 16'h0);
    if1.v_in = 1'b0;
    if2.v_in = 1'b0;
    @(posedge clk);
    #2;
    total++;
    if (if2.pf_valid !== 1'b1 || if2.pf_addr !== 16'h0011) begin
      bad++;
      $display("FAIL pre_reset_pf got v=%b a=%h want v=1 a=0011", if2.pf_valid, if2.pf_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    total += 2;
    if (if1.pf_valid !== 1'b0 || if1.pf_addr !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset_deg1 got v=%b a=%h want v=0 a=0000", if1.pf_valid, if1.pf_addr);
    end
    if (if2.pf_valid !== 1'b0 || if2.pf_addr !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset_deg2 got v=%b a=%h want v=0 a=0000", if2.pf_valid, if2.pf_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h0000, 16'h0010, 1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b0, 16'h0, 1'b0, 16'h0);
    idle(1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_cold_stream;
    test_second_stream;
    test_replay;
    test_end_of_stream;
    test_chunk_overflow;
    test_back_to_back;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/isb_prefetcher.md
Name: isb_prefetcher

Overview:
- Irregular Stream Buffer (ISB) data prefetcher: observes the demand access stream (PC, address) from the core/L1 side.
- Maps PC-localized address sequences onto a linear structural address space.
- On each access to an already-mapped address, predicts the next structural neighbours and emits them as prefetch addresses towards the memory side.

Parameters:
- DEGREE, 1, number of structural successors probed per access (legal 1..4).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- v_in  in  1  demand access valid; sampled at posedge.
- pc  in  16  PC of the access.
- addr  in  16  access address (line granularity).
- pf_valid  out  1  prefetch request valid (registered).
- pf_addr  out  16  prefetch address (registered).

Behaviour:
- Reset:
  - pf_valid=0, pf_addr=0.
  - All table valid bits cleared; round-robin pointers=0.
  - next_chunk=0x0100; probe state idle.
- Training unit (TU): 4 entries, fully associative, tag=pc, data=last_addr; allocate on miss, round-robin replacement.
- PS map (physical->structural): 32 entries, fully associative, tag=addr, data=s[15:0]; round-robin replacement.
- SP map (structural->physical): 64 entries, direct-mapped, index s[5:0], tag s[15:6], data=addr.
- All lookups are combinational on the sampled inputs. All writes happen at the sampling edge.
- Training, on an edge with v_in=1:
  - If addr hits PS: no remap.
  - Else, if TU hits pc and last_addr hits PS with s_L:
    - s_new = s_L+1 when (s_L+1)[3:0]!=0.
    - Otherwise allocate a new chunk: s_new=next_chunk; next_chunk+=16.
  - Else (TU miss, or last_addr unmapped): s_new=next_chunk; next_chunk+=16.
  - When a mapping is created: write PS[addr]=s_new and SP[s_new]=addr.
  - Always set TU[pc].last_addr=addr.
  - next_chunk wraps modulo 2^16.
  - Evicted PS entries do not invalidate SP; stale SP entries remain until overwritten.
- Prediction:
  - Uses only the PS state before this edge's write.
  - If addr hit PS with s_cur: load probe state base=s_cur, k=1.
  - Each edge while probe active: look up SP[base+k].
    - On hit: pf_valid<=1, pf_addr<=data.
    - On miss: pf_valid<=0.
  - k increments each edge; probe ends after k=DEGREE.
  - Result: candidate k is visible during cycle t+k for an access sampled at edge t.
  - A new v_in access preempts and restarts the probe.
  - When no probe is active, pf_valid<=0.
- One access per cycle max; no backpressure. pf_valid is a one-cycle pulse per prefetch.
- Reset asserted mid-operation: immediate clear of everything above.

Optional Feature:
- ISB_STATS_EN defined: adds outputs stat_acc[15:0] (accepted accesses) and stat_pf[15:0] (pf_valid pulses). Both are saturating counters, reset to 0.
- Undefined: ports and counters are absent. Core behaviour is identical either way.

Decomposition:
- Package isb_pkg holds:
  - constants TU_ENTRIES=4, PS_ENTRIES=32, SP_ENTRIES=64, CHUNK=16, CHUNK_INIT=16'h0100;
  - typedefs addr_t/saddr_t (16-bit);
  - entry structs tu_entry_t, ps_entry_t, sp_entry_t.
- One natural sub-module: isb_assoc_table, a fully associative tag/data table with round-robin replacement. It is instantiated for TU and PS.
- The SP map is inline.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> pf_valid=0 immediately; after release, a previously mapped addr gives no prefetch.
- Cold stream: pc=0x0000, addr 0x10..0x14 in consecutive cycles -> PS maps 0x10..0x14 to 0x0100..0x0104; pf_valid stays 0.
- Second stream: then pc=0x0001, addr 0x20, 0x21 -> mapped to 0x0110, 0x0111; pf_valid stays 0.
- Replay: pc=0x0000, addr=0x10 -> next cycle pf_valid=1, pf_addr=0x0011.
- End of stream: pc=0x0001, addr=0x21 -> SP[0x0112] misses, so pf_valid stays 0.
- Chunk overflow: pc=0x0002, addr 0x40..0x50 -> 0x40..0x4F map to 0x0120..0x012F and 0x50 maps to 0x0130. Replaying 0x4F -> pf_addr=0x0050.
- DEGREE=2: replay addr=0x10 -> pf_addr 0x11 then 0x12 on consecutive cycles. A new access on the second cycle suppresses 0x12.
